// File: rtl/nysa_host_ih_driver.sv
// nysa_host_ih_driver
// Host-side initiator for the wishbone_master in_*/out_* port. A local
// request (ping / write / read on the peripheral or memory bus) is turned
// into the in_* word sequence. The out_* response words are collected:
// read data is returned, the status is checked, and completion is reported.
// Optional feature: define HOST_IH_TIMEOUT_EN to enable a handshake watchdog
// of TIMEOUT_CYCLES cycles.
module nysa_host_ih_driver #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_stb,
    input  logic [1:0]  i_req_op,
    input  logic        i_req_mem,
    input  logic [31:0] i_req_addr,
    input  logic [27:0] i_req_count,
    input  logic [31:0] i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ack,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [31:0] o_status,
    input  logic        i_master_ready,
    output logic        o_in_ready,
    output logic [31:0] o_in_command,
    output logic [31:0] o_in_address,
    output logic [31:0] o_in_data,
    output logic [27:0] o_in_data_count,
    input  logic        i_out_en,
    input  logic [31:0] i_out_status,
    input  logic [31:0] i_out_address,
    input  logic [31:0] i_out_data,
    input  logic [27:0] i_out_data_count,
    output logic        o_out_ready
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RESP    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] OP_PING  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        mem_q, mem_d;
    logic [31:0] addr_q, addr_d;
    logic [27:0] count_q, count_d;
    logic [27:0] remaining_q, remaining_d;
    logic        error_q, error_d;
    logic [31:0] status_q, status_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    logic        is_write;
    logic        is_read;
    logic [31:0] command;
    logic [27:0] req_count_fixed;
    logic        in_fire;
    logic        out_fire;

    assign is_write        = (op_q == OP_WRITE);
    assign is_read         = (op_q == OP_READ);
    // Command word: memory-bus select in bit 16, opcode in the low bits.
    assign command         = {15'h0, mem_q, 14'h0, op_q};
    assign req_count_fixed = (i_req_count == 28'd0) ? 28'd1 : i_req_count;
    assign out_fire        = (state_q == ST_RESP) && i_out_en;

`ifdef HOST_IH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`else
    // Without the watchdog the block waits indefinitely for each handshake.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    // Response address and remaining count are informational only.
    logic unused_inputs;
    assign unused_inputs = ^{i_out_address, i_out_data_count};

    // Next-state, handshake and datapath update logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mem_d       = mem_q;
        addr_d      = addr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        error_d     = error_q;
        status_d    = status_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        o_in_ready  = 1'b0;
        o_wr_ack    = 1'b0;
        o_out_ready = 1'b0;
        in_fire     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req_stb) begin
                    // Reserved opcode is issued on the wire as a ping.
                    op_d        = (i_req_op == 2'b11) ? OP_PING : i_req_op;
                    mem_d       = i_req_mem;
                    addr_d      = i_req_addr;
                    count_d     = req_count_fixed;
                    remaining_d = req_count_fixed;
                    error_d     = 1'b0;
                    state_d     = ST_CMD;
                end
            end
            ST_CMD: begin
                if (i_master_ready && (!is_write || i_wr_valid)) begin
                    in_fire    = 1'b1;
                    o_in_ready = 1'b1;
                    if (is_write) begin
                        o_wr_ack    = 1'b1;
                        remaining_d = remaining_q - 28'd1;
                        // Compare before decrementing so a full-scale count never wraps.
                        state_d     = (remaining_q != 28'd1) ? ST_WR_DATA : ST_RESP;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WR_DATA: begin
                if (i_master_ready && i_wr_valid) begin
                    in_fire     = 1'b1;
                    o_in_ready  = 1'b1;
                    o_wr_ack    = 1'b1;
                    remaining_d = remaining_q - 28'd1;
                    if (remaining_q == 28'd1) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                o_out_ready = 1'b1;
                if (i_out_en) begin
                    status_d = i_out_status;
                    if (i_out_status != ~command) begin
                        error_d = 1'b1;
                    end
                    if (is_read) begin
                        rd_data_d   = i_out_data;
                        rd_valid_d  = 1'b1;
                        remaining_d = remaining_q - 28'd1;
                        if (remaining_q == 28'd1) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef HOST_IH_TIMEOUT_EN
        // Watchdog: counts handshake-free cycles while a request is active.
        wd_d = '0;
        if ((state_q == ST_CMD) || (state_q == ST_WR_DATA) || (state_q == ST_RESP)) begin
            if (in_fire || out_fire) begin
                wd_d = '0;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_d    = '0;
                error_d = 1'b1;
                state_d = ST_DONE;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'b00;
            mem_q       <= 1'b0;
            addr_q      <= 32'h0;
            count_q     <= 28'h0;
            remaining_q <= 28'h0;
            error_q     <= 1'b0;
            status_q    <= 32'h0;
            rd_data_q   <= 32'h0;
            rd_valid_q  <= 1'b0;
`ifdef HOST_IH_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mem_q       <= mem_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            error_q     <= error_d;
            status_q    <= status_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
`ifdef HOST_IH_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign o_in_command    = command;
    assign o_in_address    = addr_q;
    assign o_in_data_count = count_q;
    assign o_in_data       = (is_write && ((state_q == ST_CMD) || (state_q == ST_WR_DATA)))
                             ? i_wr_data : 32'h0;
    assign o_busy          = (state_q == ST_CMD) || (state_q == ST_WR_DATA) || (state_q == ST_RESP);
    assign o_done          = (state_q == ST_DONE);
    assign o_error         = error_q;
    assign o_status        = status_q;
    assign o_rd_data       = rd_data_q;
    assign o_rd_valid      = rd_valid_q;

endmodule

// File: tb/tb_nysa_host_ih_driver.sv
// Scoreboard bench for nysa_host_ih_driver: directed requests push their
// expected in_* words, read words and completion into a queue; a monitor
// pops and compares whenever the DUT presents one of those events.
module tb_nysa_host_ih_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req_stb = 1'b0;
    logic [1:0]  i_req_op = 2'b00;
    logic        i_req_mem = 1'b0;
    logic [31:0] i_req_addr = 32'h0;
    logic [27:0] i_req_count = 28'h0;
    logic [31:0] i_wr_data = 32'h0;
    logic        i_wr_valid = 1'b0;
    logic        o_wr_ack;
    logic [31:0] o_rd_data;
    logic        o_rd_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [31:0] o_status;
    logic        i_master_ready = 1'b1;
    logic        o_in_ready;
    logic [31:0] o_in_command;
    logic [31:0] o_in_address;
    logic [31:0] o_in_data;
    logic [27:0] o_in_data_count;
    logic        i_out_en = 1'b0;
    logic [31:0] i_out_status = 32'h0;
    logic [31:0] i_out_address = 32'h0;
    logic [31:0] i_out_data = 32'h0;
    logic [27:0] i_out_data_count = 28'h0;
    logic        o_out_ready;

    always #5 clk = ~clk;

    nysa_host_ih_driver #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .i_req_stb(i_req_stb), .i_req_op(i_req_op), .i_req_mem(i_req_mem),
        .i_req_addr(i_req_addr), .i_req_count(i_req_count),
        .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ack(o_wr_ack),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_status(o_status),
        .i_master_ready(i_master_ready), .o_in_ready(o_in_ready),
        .o_in_command(o_in_command), .o_in_address(o_in_address),
        .o_in_data(o_in_data), .o_in_data_count(o_in_data_count),
        .i_out_en(i_out_en), .i_out_status(i_out_status),
        .i_out_address(i_out_address), .i_out_data(i_out_data),
        .i_out_data_count(i_out_data_count), .o_out_ready(o_out_ready)
    );

    localparam int K_IN   = 0;
    localparam int K_RD   = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [27:0] cnt;
        logic        bitv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] wdata [0:3];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic push_in(input logic [31:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [27:0] cnt, input logic ack);
        exp_t e;
        e.kind = K_IN; e.v0 = cmd; e.v1 = addr; e.v2 = data; e.cnt = cnt; e.bitv = ack;
        exp_q.push_back(e);
    endtask

    task automatic push_rd(input logic [31:0] data);
        exp_t e;
        e.kind = K_RD; e.v0 = data; e.v1 = 32'h0; e.v2 = 32'h0; e.cnt = 28'h0; e.bitv = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic err, input logic [31:0] status);
        exp_t e;
        e.kind = K_DONE; e.v0 = status; e.v1 = 32'h0; e.v2 = 32'h0; e.cnt = 28'h0; e.bitv = err;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, input string name, output exp_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1; e.v0 = 32'h0; e.v1 = 32'h0; e.v2 = 32'h0; e.cnt = 28'h0; e.bitv = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: DUT presented an event, scoreboard expected none", name);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                n_fail++;
                $display("FAIL %s: got event kind %0d, expected kind %0d", name, kind, e.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard head.
    exp_t mon_e;
    bit   mon_ok;
    always @(negedge clk) begin
        if (rst) begin
            if (o_wr_ack && !o_in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_ack_alone: got o_wr_ack=1 with o_in_ready=0, expected both together");
            end
            if (o_in_ready) begin
                take(K_IN, "in_word", mon_e, mon_ok);
                if (mon_ok) begin
                    check32("in_command", o_in_command, mon_e.v0);
                    check32("in_address", o_in_address, mon_e.v1);
                    check32("in_data", o_in_data, mon_e.v2);
                    check32("in_count", 32'(o_in_data_count), 32'(mon_e.cnt));
                    check32("in_wr_ack", 32'(o_wr_ack), 32'(mon_e.bitv));
                end
            end
            if (o_rd_valid) begin
                take(K_RD, "rd_word", mon_e, mon_ok);
                if (mon_ok) check32("rd_data", o_rd_data, mon_e.v0);
            end
            if (o_done) begin
                take(K_DONE, "done", mon_e, mon_ok);
                if (mon_ok) begin
                    check32("done_error", 32'(o_error), 32'(mon_e.bitv));
                    check32("done_status", o_status, mon_e.v0);
                    check32("done_busy", 32'(o_busy), 32'h0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check32({name, "_ctrl"}, 32'({o_in_ready, o_wr_ack, o_rd_valid, o_busy,
                                      o_done, o_error, o_out_ready}), 32'h0);
        check32({name, "_status"}, o_status, 32'h0);
        check32({name, "_command"}, o_in_command, 32'h0);
        check32({name, "_address"}, o_in_address, 32'h0);
        check32({name, "_data"}, o_in_data, 32'h0);
        check32({name, "_count"}, 32'(o_in_data_count), 32'h0);
        check32({name, "_rd_data"}, o_rd_data, 32'h0);
    endtask

    task automatic issue(input logic [1:0] op, input logic mem,
                         input logic [31:0] addr, input logic [27:0] cnt);
        i_req_stb = 1'b1; i_req_op = op; i_req_mem = mem;
        i_req_addr = addr; i_req_count = cnt;
        tick();
        i_req_stb = 1'b0;
    endtask

    task automatic respond(input string name, input logic [31:0] status, input logic [31:0] data);
        int k = 0;
        while (!o_out_ready && k < 60) begin
            tick();
            k++;
        end
        if (!o_out_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got o_out_ready=0 after %0d cycles, expected 1", name, k);
        end else begin
            i_out_en = 1'b1; i_out_status = status; i_out_data = data;
            tick();
            i_out_en = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!o_done && k < 100) begin
            tick();
            k++;
        end
        n_checks++;
        if (!o_done) begin
            n_fail++;
            $display("FAIL %s: got o_done=0 after %0d cycles, expected 1", name, k);
        end else begin
            tick();
        end
    endtask

    // Feeds wdata[0..n-1]; vpat/mpat give i_wr_valid/i_master_ready per cycle.
    task automatic write_words(input string name, input int n,
                               input logic [15:0] vpat, input logic [15:0] mpat);
        int   idx = 0;
        int   cyc = 0;
        logic acked;
        while (idx < n && cyc < 60) begin
            i_wr_valid     = (cyc < 16) ? vpat[cyc] : 1'b1;
            i_master_ready = (cyc < 16) ? mpat[cyc] : 1'b1;
            i_wr_data      = wdata[idx];
            @(negedge clk);
            acked = o_wr_ack;
            tick();
            if (acked) idx++;
            cyc++;
        end
        i_wr_valid = 1'b0;
        i_master_ready = 1'b1;
        check32({name, "_words_acked"}, 32'(idx), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset state.
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Ping, count 0 treated as 1; out_en while still in CMD must be ignored.
        push_in(32'h0000_0000, 32'h0000_0020, 32'h0, 28'd1, 1'b0);
        push_done(1'b0, 32'hFFFF_FFFF);
        i_master_ready = 1'b0;
        issue(2'b00, 1'b0, 32'h20, 28'd0);
        i_out_en = 1'b1; i_out_status = 32'hFFFF_FFFF;
        tick();
        check32("cmd_out_ready", 32'(o_out_ready), 32'h0);
        tick();
        i_out_en = 1'b0;
        i_master_ready = 1'b1;
        respond("ping_resp", 32'hFFFF_FFFF, 32'h0);
        wait_done("ping_done");
        check32("ping_error_after", 32'(o_error), 32'h0);

        // Write 3 words with wr_valid gaps and a master_ready stall.
        wdata[0] = 32'hA; wdata[1] = 32'hB; wdata[2] = 32'hC; wdata[3] = 32'h0;
        push_in(32'h0000_0001, 32'h0000_0100, 32'hA, 28'd3, 1'b1);
        push_in(32'h0000_0001, 32'h0000_0100, 32'hB, 28'd3, 1'b1);
        push_in(32'h0000_0001, 32'h0000_0100, 32'hC, 28'd3, 1'b1);
        push_done(1'b0, 32'hFFFF_FFFE);
        issue(2'b01, 1'b0, 32'h100, 28'd3);
        write_words("write3", 3, 16'b1111_1111_1101_1001, 16'b1111_1111_1110_0111);
        respond("write_resp", 32'hFFFF_FFFE, 32'h0);
        wait_done("write_done");

        // Memory read of 4 words.
        push_in(32'h0001_0002, 32'h0, 32'h0, 28'd4, 1'b0);
        push_rd(32'h11); push_rd(32'h22); push_rd(32'h33); push_rd(32'h44);
        push_done(1'b0, 32'hFFFE_FFFD);
        issue(2'b10, 1'b1, 32'h0, 28'd4);
        respond("read_w0", 32'hFFFE_FFFD, 32'h11);
        respond("read_w1", 32'hFFFE_FFFD, 32'h22);
        respond("read_w2", 32'hFFFE_FFFD, 32'h33);
        respond("read_w3", 32'hFFFE_FFFD, 32'h44);
        wait_done("read_done");

        // Ping answered with a bad status: sticky error until the next request.
        push_in(32'h0, 32'h10, 32'h0, 28'd1, 1'b0);
        push_done(1'b1, 32'h1234_5678);
        issue(2'b00, 1'b0, 32'h10, 28'd1);
        respond("bad_resp", 32'h1234_5678, 32'h0);
        wait_done("bad_done");
        tick();
        check32("bad_error_sticky", 32'(o_error), 32'h1);
        check32("bad_status_held", o_status, 32'h1234_5678);

        // Reserved opcode behaves as a ping; the new strobe clears the error.
        push_in(32'h0, 32'h300, 32'h0, 28'd1, 1'b0);
        push_done(1'b0, 32'hFFFF_FFFF);
        issue(2'b11, 1'b0, 32'h300, 28'd0);
        check32("reserved_error_cleared", 32'(o_error), 32'h0);
        check32("reserved_busy", 32'(o_busy), 32'h1);
        respond("reserved_resp", 32'hFFFF_FFFF, 32'h0);
        wait_done("reserved_done");

        // Reset dropped after the first write word: immediate abort.
        push_in(32'h1, 32'h200, 32'hD1, 28'd3, 1'b1);
        issue(2'b01, 1'b0, 32'h200, 28'd3);
        i_wr_data = 32'hD1; i_wr_valid = 1'b1; i_master_ready = 1'b1;
        tick();
        i_wr_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        rst = 1'b1;
        tick();
        check32("mid_reset_queue", 32'(exp_q.size()), 32'h0);
        push_in(32'h0, 32'h44, 32'h0, 28'd1, 1'b0);
        push_done(1'b0, 32'hFFFF_FFFF);
        issue(2'b00, 1'b0, 32'h44, 28'd1);
        respond("post_reset_resp", 32'hFFFF_FFFF, 32'h0);
        wait_done("post_reset_done");

        // Full-scale count: two words in, the request must still be busy.
        push_in(32'h2, 32'h40, 32'h0, 28'hFFF_FFFF, 1'b0);
        push_rd(32'h5); push_rd(32'h6);
        issue(2'b10, 1'b0, 32'h40, 28'hFFF_FFFF);
        respond("big_w0", 32'hFFFF_FFFD, 32'h5);
        respond("big_w1", 32'hFFFF_FFFD, 32'h6);
        tick();
        tick();
        check32("big_still_busy", 32'({o_busy, o_done}), 32'h2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

`ifdef HOST_IH_TIMEOUT_EN
        // Read with no response: watchdog ends it with an error.
        push_in(32'h2, 32'h80, 32'h0, 28'd1, 1'b0);
        push_done(1'b1, 32'h0);
        issue(2'b10, 1'b0, 32'h80, 28'd1);
        wait_done("timeout_done");
`endif

        tick();
        check32("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
